// File: rtl/onehot_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_pkg
//  Description : Shared constants and types for the registered 4-to-2
//                one-hot encoder and its combinational priority core.
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_encoder_pkg;

  // Input word width; the encoder is only defined for a 4-bit one-hot word.
  localparam int ENC_N     = 4;
  // Code width, equal to $clog2(ENC_N).
  localparam int ENC_W     = 2;
  // Width of the saturating transfer counter.
  localparam int ENC_CNT_W = 8;

  typedef logic [ENC_W-1:0] enc_code_t;

  // Output stage occupancy: EMPTY has nothing pending, FULL holds a result.
  typedef enum logic [0:0] {
    ENC_EMPTY = 1'b0,
    ENC_FULL  = 1'b1
  } enc_state_e;

endpackage : onehot_encoder_pkg
`default_nettype wire

// File: rtl/onehot_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_prio_enc
//  Description : Purely combinational lowest-set-bit priority encoder.
//                Produces the binary index of the lowest set bit, a flag for
//                an all-zero word and a multi-hot flag.
//  Config      : ONEHOT_ENCODER_ERRCHK_EN - when defined, multi_o reports a
//                population count of two or more; when undefined the check
//                is absent and multi_o is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_prio_enc
  import onehot_encoder_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic [N-1:0] d_i,
  output logic [W-1:0] code_o,
  output logic         zero_o,
  output logic         multi_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    code_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d_i[i]) begin
        code_o = W'(i);
      end
    end
  end

  // An all-zero word encodes to index 0, so it needs its own flag.
  assign zero_o = ~|d_i;

`ifdef ONEHOT_ENCODER_ERRCHK_EN
  // Two or more set bits make the word multi-hot.
  assign multi_o = ($countones(d_i) > 1);
`else
  assign multi_o = 1'b0;
`endif

endmodule : onehot_prio_enc
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder
//  Description : Registered 4-to-2 one-hot encoder with valid/ready on both
//                sides. A word accepted on the input appears as a registered
//                code one cycle later, with zero and multi-hot flags and a
//                saturating count of accepted words. in_ready depends only on
//                the registered output state and out_ready.
//  Config      : ONEHOT_ENCODER_ERRCHK_EN - enables the multi-hot check that
//                drives err; when undefined err is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder
  import onehot_encoder_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int W     = ENC_W,
  parameter int CNT_W = ENC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     code,
  output logic             zero,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  enc_state_e       state_q;
  enc_state_e       state_d;
  logic [W-1:0]     code_q;
  logic             zero_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [W-1:0]     w_enc_code;
  logic             w_enc_zero;
  logic             w_enc_multi;
  logic             w_accept;
  logic             w_cnt_sat;

  onehot_prio_enc #(
    .N (N),
    .W (W)
  ) u_prio_enc (
    .d_i     (d),
    .code_o  (w_enc_code),
    .zero_o  (w_enc_zero),
    .multi_o (w_enc_multi)
  );

  // The output stage can take a word when empty or when it drains this cycle.
  assign out_valid = (state_q == ENC_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // Occupancy transitions: fill on accept, empty only on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_EMPTY: begin
        if (w_accept) begin
          state_d = ENC_FULL;
        end
      end
      ENC_FULL: begin
        if (out_ready && !w_accept) begin
          state_d = ENC_EMPTY;
        end
      end
      default: begin
        state_d = ENC_EMPTY;
      end
    endcase
  end

  // State and result register; results load only on accept and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENC_EMPTY;
      code_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        code_q <= w_enc_code;
        zero_q <= w_enc_zero;
        // With the check compiled out w_enc_multi is constant 0, so this
        // flop never leaves its reset value and folds to a tie-off.
        err_q  <= w_enc_multi;
      end
    end
  end

  assign code = code_q;
  assign zero = zero_q;
  assign err  = err_q;

  // Saturating increment: stop at all-ones rather than wrap.
  assign w_cnt_sat = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept && !w_cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

endmodule : onehot_encoder
`default_nettype wire

// File: doc/onehot_encoder.md
# onehot_encoder

Registered 4-to-2 one-hot encoder: the inverse of the team's 2-to-4 decoder. It accepts a 4-bit one-hot word on a valid/ready handshake and returns the 2-bit binary index one cycle later on a registered valid/ready output. It also flags an all-zero input and, optionally, a multi-hot input. It sits on the return path wherever decoded select lines must be re-encoded, for example in loop-back checking of the decoder.

## Interface
- N, 4, input word width; only 4 is supported.
- W, 2, code width; equals $clog2(N).
- CNT_W, 8, width of the transfer counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- d  in  N  one-hot word; d[i] maps to code i. Wiring {y4,y3,y2,y1} from the decoder reproduces {a,b}.
- out_valid  out  1  result registered and pending.
- out_ready  in  1  downstream accepts the result.
- code  out  W  encoded index.
- zero  out  1  the accepted word was 4'b0000.
- err  out  1  the accepted word had more than one bit set; tied 0 when the check is compiled out.
- xfer_cnt  out  CNT_W  saturating count of accepted input words.

## Operation
- Accept: a word is accepted when in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready. It is combinational, and it is 1 while the output stage is empty or draining.
- Encoding: the lowest set bit wins. 0001→0, 0010→1, 0100→2, 1000→3.
- Zero input: d=0000 produces code=0 and zero=1. A zero word still counts as a transfer.
- Multi-hot input: the lowest set bit still gives the code. 0110→1, and err=1 when the check is compiled in.
- Output register: on accept, code, zero and err load from d, and out_valid goes to 1.
- Hold: while out_valid && !out_ready, the output register holds. code, zero and err must be stable and in_ready=0.
- Clear: on out_ready with no new accept, out_valid goes to 0. code, zero and err keep their last values.
- Simultaneous events: accept and out_ready in the same cycle load the new result and keep out_valid=1. This gives full throughput of one word per cycle.
- xfer_cnt increments by 1 per accept and saturates at 2^CNT_W-1. It never wraps.
- State machine with 2 states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on out_ready with no accept.
  - FULL → FULL on hold, or on drain plus accept.

## Timing
- Latency: a word accepted at edge k appears on code/out_valid after edge k, one cycle later.
- Reset values: out_valid=0, code=0, zero=0, err=0, xfer_cnt=0. in_ready therefore reads 1 during and after reset.
- Reset asserted mid-transfer: any pending result is dropped immediately (asynchronous). No output is produced for a word presented in the reset cycle.
- Input stability: d is sampled only on the accept edge. Changes while in_ready=0 have no effect.
- No combinational path exists from d to any output. The only combinational path is from out_ready to in_ready.

## Configuration
- Macro: ONEHOT_ENCODER_ERRCHK_EN.
- Defined: a population-count check on d. err is registered as 1 for any accept with two or more bits set.
- Undefined: the check logic is absent and err is constant 0. Encoding, priority and all other behaviour are identical.

## Structure
- Package onehot_encoder_pkg holds:
  - constants ENC_N=4, ENC_W=2 and ENC_CNT_W=8;
  - typedef enc_code_t (logic [ENC_W-1:0]);
  - typedef enc_state_e {ENC_EMPTY, ENC_FULL}.
- Sub-module onehot_prio_enc: purely combinational lowest-bit priority encoder. It produces code, zero and multi from d. The top module owns the handshake register, the state and the counter.

## Test plan
- Reset, then d=0001, 0010, 0100, 1000 on consecutive cycles with out_ready=1 → code 0,1,2,3 one cycle after each accept; out_valid held at 1 throughout; xfer_cnt=4.
- d=0000 accepted → code=0, zero=1, err=0. With the macro defined, d=0110 → code=1, err=1; without the macro, err=0.
- Backpressure: out_ready=0 after accepting d=0100 → in_ready=0, code=2 held for 5 cycles. A new d=1000 is ignored until out_ready=1, then code=3.
- Decoder loop-back: drive {a,b}=00,01,10,11 into the decoder and feed {y4,y3,y2,y1} into d → code equals {a,b} each time; zero=0 and err=0.
- Saturation: 300 back-to-back accepts → xfer_cnt stops at 255.
- Assert rst while out_valid=1 with code=3 → out_valid, code and xfer_cnt read 0 immediately; in_ready=1; first accept after release gives the correct code.
